// File: rtl/count_ctrl.sv
// Prescaled up-counter with start/stop/pause control and one-shot or auto-reload terminal count.
// tc/div/mode are captured only when a count is launched from IDLE or DONE.
module count_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PDIV_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [WIDTH-1:0]  tc,
    input  logic [PDIV_W-1:0] div,
    output logic [WIDTH-1:0]  cnt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [PDIV_W-1:0]   pre_q, pre_d;
    logic [WIDTH-1:0]    tc_l_q, tc_l_d;
    logic [PDIV_W-1:0]   div_l_q, div_l_d;
    logic                mode_l_q, mode_l_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pre_q    <= '0;
            tc_l_q   <= '0;
            div_l_q  <= '0;
            mode_l_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            tc_l_q   <= tc_l_d;
            div_l_q  <= div_l_d;
            mode_l_q <= mode_l_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        tc_l_d   = tc_l_q;
        div_l_d  = div_l_q;
        mode_l_d = mode_l_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // stop has priority over start in every state
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    pre_d    = '0;
                    tc_l_d   = tc;
                    div_l_d  = div;
                    mode_l_d = mode;
                end else if (state_q == StIdle) begin
                    cnt_d = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StHold;
                end else if (pre_q == div_l_q) begin
                    pre_d = '0;
                    if (cnt_q != tc_l_q) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        done_d = 1'b1;
                        if (mode_l_q) begin
                            cnt_d = '0;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    pre_d = pre_q + PDIV_W'(1);
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cnt   = cnt_q;
    assign busy  = (state_q == StRun) || (state_q == StHold);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: a behavioural model queues expected outputs per edge,
// plus directed latency and asynchronous-reset checks.
module tb_count_ctrl;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned PDIV_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop, mode;
    logic [WIDTH-1:0]  tc;
    logic [PDIV_W-1:0] div;
    logic [WIDTH-1:0]  cnt;
    logic              busy, done;
    logic [1:0]        state;

    count_ctrl #(.WIDTH(WIDTH), .PDIV_W(PDIV_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .tc    (tc),
        .div   (div),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic             bsy;
        logic             dn;
        logic [WIDTH-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic [1:0]        m_st;
    logic [WIDTH-1:0]  m_cnt, m_tc;
    logic [PDIV_W-1:0] m_pre, m_div;
    logic              m_mode, m_done;

    task automatic check_eq(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 2'b00; m_cnt = '0; m_pre = '0; m_tc = '0; m_div = '0; m_mode = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic md,
                              input logic [WIDTH-1:0] t, input logic [PDIV_W-1:0] d);
        logic tick;
        m_done = 1'b0;
        case (m_st)
            2'b00, 2'b11: begin
                if (sp) begin
                    m_st = 2'b00; m_cnt = '0;
                end else if (st) begin
                    m_st = 2'b01; m_cnt = '0; m_pre = '0; m_tc = t; m_div = d; m_mode = md;
                end
            end
            2'b01: begin
                if (sp) m_st = 2'b10;
                else begin
                    tick = (m_pre == m_div);
                    m_pre = tick ? '0 : m_pre + 1'b1;
                    if (tick && m_cnt == m_tc) begin
                        m_done = 1'b1;
                        if (m_mode) m_cnt = '0;
                        else m_st = 2'b11;
                    end else if (tick) begin
                        m_cnt = m_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (sp) begin
                    m_st = 2'b00; m_cnt = '0;
                end else if (st) begin
                    m_st = 2'b01;
                end
            end
        endcase
    endtask

    // Called at posedge+1: drive, predict, wait one edge, compare.
    task automatic cycle(input logic st, input logic sp, input logic md,
                         input logic [WIDTH-1:0] t, input logic [PDIV_W-1:0] d);
        exp_t e;
        start = st; stop = sp; mode = md; tc = t; div = d;
        model_step(st, sp, md, t, d);
        e.st = m_st; e.bsy = (m_st == 2'b01) || (m_st == 2'b10); e.dn = m_done; e.c = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq("state", int'(state), int'(e.st));
            check_eq("busy", int'(busy), int'(e.bsy));
            check_eq("done", int'(done), int'(e.dn));
            check_eq("cnt", int'(cnt), int'(e.c));
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'($urandom), WIDTH'($urandom), PDIV_W'($urandom));
    endtask

    // Edges until done is observed, with a bound.
    task automatic run_until_done(input int max, output int n);
        n = 0;
        do begin
            idle_cycle();
            n++;
        end while (!done && n < max);
        if (!done) check_eq("done_timeout", 0, 1);
    endtask

    int n;

    initial begin
        model_reset();
        rst = 1'b0; start = 0; stop = 0; mode = 0; tc = '0; div = '0;
        #1;
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_cnt", int'(cnt), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // One-shot tc=5 div=0
        cycle(1, 0, 0, 4'd5, 4'd0);
        run_until_done(40, n);
        check_eq("oneshot_latency", n, 6);
        check_eq("oneshot_cnt", int'(cnt), 5);
        idle_cycle();
        idle_cycle();
        cycle(0, 1, 0, 0, 0);

        // start+stop together in IDLE
        cycle(1, 1, 0, 4'd3, 4'd0);

        // Auto-reload tc=3 div=1, inputs scrambled while busy
        cycle(1, 0, 1, 4'd3, 4'd1);
        run_until_done(40, n);
        check_eq("reload_first", n, 8);
        run_until_done(40, n);
        check_eq("reload_period", n, 8);
        run_until_done(40, n);
        check_eq("reload_period2", n, 8);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Pause at cnt=4, hold 10 cycles, resume
        cycle(1, 0, 0, 4'd9, 4'd0);
        repeat (4) idle_cycle();
        check_eq("pause_pre", int'(cnt), 4);
        cycle(0, 1, 0, 0, 0);
        repeat (10) idle_cycle();
        check_eq("hold_cnt", int'(cnt), 4);
        cycle(1, 0, 0, 4'd1, 4'd3);
        check_eq("resume_cnt", int'(cnt), 4);
        idle_cycle();
        check_eq("resume_next", int'(cnt), 5);
        run_until_done(40, n);
        cycle(1, 1, 0, 0, 0);

        // start+stop together in RUN -> HOLD
        cycle(1, 0, 0, 4'd7, 4'd0);
        idle_cycle();
        cycle(1, 1, 0, 0, 0);
        check_eq("ss_run_hold", int'(state), 2);
        cycle(0, 1, 0, 0, 0);

        // tc=0 div=2 one-shot
        cycle(1, 0, 0, 4'd0, 4'd2);
        run_until_done(40, n);
        check_eq("tc0_latency", n, 3);
        idle_cycle();

        // tc=0 div=0 auto-reload: done every cycle
        cycle(1, 0, 1, 4'd0, 4'd0);
        repeat (5) idle_cycle();
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Random control traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
                  WIDTH'($urandom), PDIV_W'($urandom_range(0, 2)));
        end
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Asynchronous reset mid-count at cnt=7
        cycle(1, 0, 0, 4'd12, 4'd0);
        repeat (7) idle_cycle();
        check_eq("pre_rst_cnt", int'(cnt), 7);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_state", int'(state), 0);
        check_eq("arst_cnt", int'(cnt), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_done", int'(done), 0);
        model_reset();
        @(posedge clk); #1;
        check_eq("arst_no_done", int'(done), 0);
        rst = 1'b1;
        cycle(1, 0, 0, 4'd2, 4'd0);
        run_until_done(40, n);
        check_eq("post_rst_latency", n, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the count register width.
REQ-002 Parameter PDIV_W, default 4, SHALL set the prescaler width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL start the count from IDLE or DONE, and SHALL resume it from HOLD.
REQ-006 stop  input  1  SHALL request pause (from RUN) or abort (from HOLD/DONE).
REQ-007 mode  input  1  SHALL select 0 = one-shot or 1 = auto-reload.
REQ-008 tc  input  WIDTH  SHALL carry the terminal count.
REQ-009 div  input  PDIV_W  SHALL set the prescale divisor; one count tick SHALL occur every div+1 clocks.
REQ-010 cnt  output  WIDTH  SHALL present the current count value.
REQ-011 busy  output  1  SHALL be high while state is RUN or HOLD.
REQ-012 done  output  1  SHALL be a one-cycle terminal-count pulse.
REQ-013 state  output  2  SHALL encode IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-014 tc, div and mode SHALL be latched (tc_l, div_l, mode_l) on any start-taken edge from IDLE or DONE, and SHALL be ignored at all other times.
REQ-015 A start-taken edge from IDLE or DONE SHALL clear cnt and the prescaler and SHALL set state to RUN.
REQ-016 In RUN, the prescaler SHALL count 0..div_l; a tick SHALL occur on each edge where prescaler == div_l, and the prescaler SHALL return to 0 on that edge.
REQ-017 On a tick with cnt != tc_l, cnt SHALL increment by 1.
REQ-018 On a tick with cnt == tc_l and mode_l = 0, state SHALL go to DONE, cnt SHALL hold at tc_l, and done SHALL be 1 for the next cycle.
REQ-019 On a tick with cnt == tc_l and mode_l = 1, cnt SHALL go to 0, state SHALL remain RUN, and done SHALL be 1 for the next cycle.
REQ-020 Terminal-count latency SHALL be (tc_l+1)*(div_l+1) edges after RUN entry.
REQ-021 stop in RUN SHALL move state to HOLD, freezing cnt and the prescaler; a tick on that same edge SHALL be suppressed.
REQ-022 start in HOLD SHALL return state to RUN with cnt and the prescaler preserved.
REQ-023 stop in HOLD or DONE SHALL move state to IDLE and clear cnt.
REQ-024 When start and stop are asserted on the same edge, stop SHALL win in every state.
REQ-025 start in RUN SHALL be ignored (no restart).
REQ-026 In IDLE, start=0 SHALL hold state at IDLE with cnt = 0.
REQ-027 In DONE, cnt SHALL hold tc_l until start or stop is taken.
REQ-028 With tc_l = 0, the first tick SHALL complete the count.
REQ-029 With div_l = 0, a tick SHALL occur on every RUN edge.
REQ-030 done SHALL be registered and SHALL never be high for two consecutive cycles unless tc_l = 0, div_l = 0 and mode_l = 1, in which case it SHALL be high every cycle.
REQ-031 Changes to tc, div or mode while busy SHALL have no effect.

Reset
REQ-032 rst = 0 SHALL immediately, without waiting for a clock, force state to IDLE and clear cnt, the prescaler, tc_l, div_l, mode_l, busy and done.
REQ-033 After rst is released, the first start SHALL be honoured on the first rising edge.
REQ-034 A reset asserted mid-count SHALL abort the count, with no done pulse.

Verification
REQ-035 One-shot, tc=5, div=0, start for 1 cycle -> cnt 0,1,2,3,4,5 on successive edges; done=1 for exactly one cycle, 6 edges after RUN entry; state then DONE with cnt=5.
REQ-036 Auto-reload, tc=3, div=1 -> cnt 0,0,1,1,2,2,3,3,0,...; done pulses every 8 clocks; busy stays 1.
REQ-037 Pause, one-shot tc=9 div=0, stop at cnt=4 -> state HOLD with cnt frozen at 4 for 10 cycles; start -> resumes at 5; done after 5 further ticks.
REQ-038 start and stop on the same edge in IDLE -> stays IDLE; the same in RUN -> HOLD.
REQ-039 tc=0, div=2, one-shot -> done 3 clocks after RUN entry; cnt stays 0 throughout.
REQ-040 rst pulled low asynchronously between clock edges during RUN at cnt=7 -> outputs 0 and state IDLE before the next edge; no done pulse.
